// File: rtl/mem_pause_ctrl_pkg.sv
// Shared CPU constants for the memory pause sequencer: FSM encoding,
// default timeout, fetch byte-enable and the registered bus transfer record.
package mem_pause_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DATA_WAIT  = 2'd1,
    ST_INSTR_WAIT = 2'd2
  } mp_state_e;

  localparam int         DEFAULT_TIMEOUT_CYCLES = 255;
  localparam logic [3:0] FETCH_SEL              = 4'hF;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } bus_xfer_t;

  function automatic bus_xfer_t fetch_xfer(input logic [31:0] addr);
    bus_xfer_t x;
    x.wen   = 1'b0;
    x.addr  = addr;
    x.wdata = 32'h0;
    x.sel   = FETCH_SEL;
    return x;
  endfunction

endpackage

// File: rtl/mem_pause_timer.sv
// Wait-state counter: cleared by clr, counts enabled cycles, flags expire
// on the cycle that would bring the count to TIMEOUT_CYCLES.
module mem_pause_timer
  import mem_pause_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

  assign expire = en & (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_pause_ctrl.sv
// Serialises IF and MEM accesses onto one req/ack bus and pauses the pipeline
// until both complete. Optional wait-state timeout: MEM_PAUSE_TIMEOUT_EN.
module mem_pause_ctrl
  import mem_pause_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        mem_req_i,
  input  logic        mem_wen_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  output logic        bus_req_o,
  output logic        bus_wen_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_sel_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] if_rdata_o,
  output logic [31:0] mem_rdata_o,
  output logic        pause_o,
  output logic        bus_err_o,
  output logic        bus_err_instr_o
);

  mp_state_e state;
  bus_xfer_t xfer;
  bus_xfer_t data_xfer;
  logic      if_done, mem_done;
  logic      if_pend, mem_pend;
  logic      tmo;

  assign if_pend = if_req_i & ~if_done;
  assign mem_pend = mem_req_i & ~mem_done;
  assign pause_o = if_pend | mem_pend;

  assign data_xfer = '{wen: mem_wen_i, addr: mem_addr_i, wdata: mem_wdata_i, sel: mem_sel_i};

  assign bus_wen_o   = xfer.wen;
  assign bus_addr_o  = xfer.addr;
  assign bus_wdata_o = xfer.wdata;
  assign bus_sel_o   = xfer.sel;

`ifdef MEM_PAUSE_TIMEOUT_EN
  logic err_q, err_instr_q;

  mem_pause_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (~bus_req_o | bus_ack_i | tmo),
    .en     (bus_req_o & ~bus_ack_i),
    .expire (tmo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_instr_q <= 1'b0;
    end else begin
      err_q       <= tmo;
      err_instr_q <= tmo & (state == ST_INSTR_WAIT);
    end
  end

  assign bus_err_o       = err_q;
  assign bus_err_instr_o = err_instr_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg  = |TIMEOUT_CYCLES;
  assign tmo             = 1'b0;
  assign bus_err_o       = 1'b0;
  assign bus_err_instr_o = 1'b0;
`endif

  // Flags clear on the advancing edge; a set in the same edge cannot occur
  // because a WAIT state always implies pause_o is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
      bus_req_o   <= 1'b0;
      xfer        <= '0;
      if_rdata_o  <= '0;
      mem_rdata_o <= '0;
    end else begin
      if (!pause_o) begin
        if_done  <= 1'b0;
        mem_done <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (mem_pend) begin
            xfer      <= data_xfer;
            bus_req_o <= 1'b1;
            state     <= ST_DATA_WAIT;
          end else if (if_pend) begin
            xfer      <= fetch_xfer(if_addr_i);
            bus_req_o <= 1'b1;
            state     <= ST_INSTR_WAIT;
          end
        end
        ST_DATA_WAIT: begin
          if (bus_ack_i || tmo) begin
            mem_done <= 1'b1;
            if (tmo)            mem_rdata_o <= '0;
            else if (!xfer.wen) mem_rdata_o <= bus_rdata_i;
            // Chain straight into the fetch to save the IDLE cycle.
            if (if_pend) begin
              xfer  <= fetch_xfer(if_addr_i);
              state <= ST_INSTR_WAIT;
            end else begin
              bus_req_o <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end
        ST_INSTR_WAIT: begin
          if (bus_ack_i || tmo) begin
            if_done    <= 1'b1;
            if_rdata_o <= tmo ? 32'h0 : bus_rdata_i;
            bus_req_o  <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: begin
          bus_req_o <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pause_ctrl.sv
// Randomised bench for mem_pause_ctrl: a slot-level timeline model predicts
// pause, bus request/fields, read data and error pulse for every cycle.
module tb_mem_pause_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, mem_req_i, mem_wen_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_sel_i;
  logic        bus_req_o, bus_wen_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_sel_o;
  logic [31:0] if_rdata_o, mem_rdata_o;
  logic        pause_o, bus_err_o, bus_err_instr_o;

  mem_pause_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .mem_req_i(mem_req_i), .mem_wen_i(mem_wen_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i),
    .bus_req_o(bus_req_o), .bus_wen_o(bus_wen_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .if_rdata_o(if_rdata_o), .mem_rdata_o(mem_rdata_o),
    .pause_o(pause_o), .bus_err_o(bus_err_o), .bus_err_instr_o(bus_err_instr_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Model state for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_pause, exp_req, exp_wen, exp_err;
  logic [31:0] exp_addr, exp_wdata, cur_if, cur_mem;
  logic [3:0]  exp_sel;
  logic [31:0] addr_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pause", pause_o, exp_pause);
      chk("bus_req", bus_req_o, exp_req);
      if (exp_req) begin
        chk("bus_addr", bus_addr_o, exp_addr);
        chk("bus_wen", bus_wen_o, exp_wen);
        chk("bus_sel", bus_sel_o, exp_sel);
        if (exp_wen) chk("bus_wdata", bus_wdata_o, exp_wdata);
      end
      chk("if_rdata", if_rdata_o, cur_if);
      chk("mem_rdata", mem_rdata_o, cur_mem);
      chk("bus_err", bus_err_o, exp_err);
      if (exp_err) chk("bus_err_instr", bus_err_instr_o, 1'b0);
    end
  end

  // One pipeline slot: requests held until pause drops, then the pipeline
  // advances. Timeline: data req cycles 1..1+wm, fetch right after, release
  // one cycle after the last ack.
  task automatic run_slot(
    input bit ifr, input logic [31:0] ia, input logic [31:0] ird, input int wi,
    input bit mr, input bit wen, input logic [31:0] ma, input logic [31:0] wd,
    input logic [3:0] sel, input logic [31:0] mrd, input int wm, input bit mtmo,
    output int hi, output int errs);
    int fs, fe, last, d;
    bit in_d, in_f, sched;
    hi = 0; errs = 0;
    fs = mr ? 2 + wm : 1;
    fe = fs + wi;
    last = ifr ? fe : (mr ? 1 + wm : -1);
    d = last + 1;
    for (int c = 0; c <= d; c++) begin
      if_req_i = ifr; if_addr_i = ia;
      mem_req_i = mr; mem_wen_i = wen; mem_addr_i = ma; mem_wdata_i = wd; mem_sel_i = sel;
      in_d = mr && c >= 1 && c <= 1 + wm;
      in_f = ifr && c >= fs && c <= fe;
      if (mr && c == 2 + wm && (mtmo || !wen)) cur_mem = mtmo ? 32'h0 : mrd;
      if (ifr && c == fe + 1) cur_if = ird;
      exp_pause = (c < d);
      exp_req   = in_d | in_f;
      exp_addr  = in_d ? ma : ia;
      exp_wen   = in_d ? wen : 1'b0;
      exp_wdata = wd;
      exp_sel   = in_d ? sel : 4'hF;
      exp_err   = mtmo && mr && c == 2 + wm;
      sched = (mr && !mtmo && c == 1 + wm) || (ifr && c == fe);
      bus_ack_i   = sched || (!exp_req && $urandom_range(0, 3) == 0);
      bus_rdata_i = (mr && c == 1 + wm) ? mrd : (ifr && c == fe) ? ird : $urandom;
      @(negedge clk);
      if (pause_o) hi++;
      if (bus_err_o) errs++;
      if (bus_req_o) addr_log.push_back(bus_addr_o);
      @(posedge clk); #1;
    end
    bus_ack_i = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pause"}, pause_o, 1'b0);
    chk({tag, "_bus_req"}, bus_req_o, 1'b0);
    chk({tag, "_bus_wen"}, bus_wen_o, 1'b0);
    chk({tag, "_bus_addr"}, bus_addr_o, 32'h0);
    chk({tag, "_bus_wdata"}, bus_wdata_o, 32'h0);
    chk({tag, "_bus_sel"}, bus_sel_o, 4'h0);
    chk({tag, "_if_rdata"}, if_rdata_o, 32'h0);
    chk({tag, "_mem_rdata"}, mem_rdata_o, 32'h0);
    chk({tag, "_bus_err"}, bus_err_o, 1'b0);
    chk({tag, "_bus_err_instr"}, bus_err_instr_o, 1'b0);
  endtask

  task automatic random_slots(input int n);
    int hi, errs;
    for (int k = 0; k < n; k++) begin
      run_slot($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 3),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom,
               4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3), 1'b0, hi, errs);
    end
  endtask

  initial begin
    int hi, errs;
    rst = 1'b1;
    if_req_i = 0; mem_req_i = 0; mem_wen_i = 0;
    if_addr_i = 0; mem_addr_i = 0; mem_wdata_i = 0; mem_sel_i = 0;
    bus_ack_i = 0; bus_rdata_i = 0;
    cur_if = 0; cur_mem = 0;
    exp_pause = 0; exp_req = 0; exp_wen = 0; exp_err = 0;
    exp_addr = 0; exp_wdata = 0; exp_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // Zero-wait fetch
    run_slot(1, 32'h00400000, 32'h24020001, 0, 0, 0, 0, 0, 0, 0, 0, 0, hi, errs);
    chk("fetch_pause_cycles", hi, 2);
    chk("fetch_rdata_lit", if_rdata_o, 32'h24020001);

    // Load + fetch, zero-wait
    addr_log.delete();
    run_slot(1, 32'h100, 32'hA5A50001, 0, 1, 0, 32'h2000, 0, 4'hF, 32'h11223344, 0, 0, hi, errs);
    chk("dual_pause_cycles", hi, 3);
    chk("dual_bus_cycles", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("dual_first_addr", addr_log[0], 32'h2000);
      chk("dual_second_addr", addr_log[1], 32'h100);
    end
    chk("dual_mem_rdata_lit", mem_rdata_o, 32'h11223344);

    // Store with two wait states
    addr_log.delete();
    run_slot(0, 0, 0, 0, 1, 1, 32'h3000, 32'hDEADBEEF, 4'b0011, 32'hFFFFFFFF, 2, 0, hi, errs);
    chk("store_pause_cycles", hi, 4);
    chk("store_req_cycles", addr_log.size(), 3);
    chk("store_mem_rdata_kept", mem_rdata_o, 32'h11223344);

    random_slots(60);

    // Async reset in DATA_WAIT
    chk_en = 1'b0;
    mem_req_i = 1; mem_wen_i = 0; mem_addr_i = 32'h44; mem_sel_i = 4'hF; if_req_i = 0;
    bus_ack_i = 0;
    @(posedge clk); #1;
    chk("rst_pre_req", bus_req_o, 1'b1);
    #2;
    rst = 1'b1; mem_req_i = 0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    cur_if = 0; cur_mem = 0;
    chk_en = 1'b1;

    random_slots(20);

`ifdef MEM_PAUSE_TIMEOUT_EN
    run_slot(0, 0, 0, 0, 1, 0, 32'h5000, 0, 4'hF, 32'hBAD0BAD0, TMO - 1, 1, hi, errs);
    chk("tmo_pause_cycles", hi, 5);
    chk("tmo_err_pulses", errs, 1);
    chk("tmo_mem_rdata_lit", mem_rdata_o, 32'h0);
    random_slots(10);
`endif

    chk_en = 1'b0;
    if_req_i = 0; mem_req_i = 0;
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_pause_ctrl.md
# mem_pause_ctrl

Pipeline-side memory sequencer: the block that drives the hazard unit's `pause` input. It serialises the instruction-fetch (IF) and data (MEM) requests onto one shared req/ack memory bus. It holds `pause_o` high until every access presented this cycle has completed, and returns the captured read data to the stages.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: wait-state limit before abandoning a transfer; used only with the timeout feature.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `if_req_i`  in  1  IF stage requests an instruction read.
- `if_addr_i`  in  32  fetch address.
- `mem_req_i`  in  1  MEM stage requests a data access.
- `mem_wen_i`  in  1  1 = write, 0 = read.
- `mem_addr_i`  in  32  data address.
- `mem_wdata_i`  in  32  store data.
- `mem_sel_i`  in  4  byte enables.
- `bus_req_o`  out  1  bus request, held until acknowledged.
- `bus_wen_o`  out  1  registered write enable.
- `bus_addr_o`  out  32  registered address.
- `bus_wdata_o`  out  32  registered write data.
- `bus_sel_o`  out  4  registered byte enables; 4'hF for fetches.
- `bus_ack_i`  in  1  slave completes the transfer this cycle.
- `bus_rdata_i`  in  32  read data, valid with `bus_ack_i`.
- `if_rdata_o`  out  32  last fetched instruction, registered.
- `mem_rdata_o`  out  32  last loaded word, registered.
- `pause_o`  out  1  freezes the whole pipeline (to the hazard unit `pause`).
- `bus_err_o`  out  1  one-cycle timeout pulse.
- `bus_err_instr_o`  out  1  qualifies `bus_err_o`: 1 = fetch timed out, 0 = data.

## Operation
- Internal flags `if_done` and `mem_done` are set on completion of the respective access.
- `pause_o = (if_req_i & ~if_done) | (mem_req_i & ~mem_done)`. It is combinational, so there is no cycle lost on release.
- Both flags clear on any rising edge where `pause_o==0`, i.e. when the pipeline advances.
- FSM states: IDLE, DATA_WAIT, INSTR_WAIT.
- IDLE:
  - If `mem_req_i & ~mem_done`, register the mem address, data, wen and sel, then go to DATA_WAIT.
  - Else if `if_req_i & ~if_done`, register the fetch address with wen=0 and sel=F, then go to INSTR_WAIT.
  - Data has priority over instruction.
- `bus_req_o=1` exactly in the WAIT states.
- DATA_WAIT with `bus_ack_i`:
  - Set `mem_done`.
  - Capture `bus_rdata_i` into `mem_rdata_o` on reads only.
  - If a fetch is still pending, load the fetch fields and go directly to INSTR_WAIT. Otherwise go to IDLE.
- INSTR_WAIT with `bus_ack_i`: capture into `if_rdata_o`, set `if_done`, go to IDLE.
- `bus_ack_i` outside the WAIT states is ignored.
- Requests and their fields are stable while `pause_o=1`, because the frozen pipeline guarantees it. A started transfer always runs to ack; it is never aborted except by timeout or reset.
- Reset values:
  - FSM = IDLE, both flags 0.
  - All bus outputs 0.
  - `if_rdata_o` and `mem_rdata_o` = 0.
  - `bus_err_o` and `bus_err_instr_o` = 0.
  - With no requests, `pause_o` = 0.
- Reset mid-transfer returns to IDLE immediately with `bus_req_o` low. The pending access is re-issued after reset only if still requested.

## Timing
- Zero-wait slave (ack in the first req cycle):
  - Single access: `pause_o` high 2 cycles.
  - Data + fetch: 3 cycles.
- Each slave wait state adds one cycle.
- Read data is valid on `*_rdata_o` in the first cycle `pause_o` is low, and holds until the next capture.

## Configuration
- `MEM_PAUSE_TIMEOUT_EN` defined:
  - A wait counter resets on entry to each WAIT state and increments every WAIT cycle without ack.
  - On reaching `TIMEOUT_CYCLES`, the FSM drops `bus_req_o` and sets the corresponding done flag.
  - The rdata register is loaded with 0, and `bus_err_o` pulses for one cycle with `bus_err_instr_o` set accordingly.
  - The FSM then continues as if acked.
- Undefined: no counter; the FSM waits indefinitely; `bus_err_o` and `bus_err_instr_o` are tied 0.

## Structure
- FSM state encodings and the default timeout constant live in the shared CPU constants package.
- The bus sel value for fetches (4'hF) also lives there.
- Sub-module `mem_pause_timer`: the wait counter with clear, enable and expire outputs. It is instantiated only under `MEM_PAUSE_TIMEOUT_EN`.

## Test plan
- Fetch only, addr 0x00400000, ack on first req cycle, rdata 0x24020001:
  - `pause_o` high 2 cycles.
  - `if_rdata_o` = 0x24020001 on release.
- Simultaneous fetch 0x100 and load 0x2000, zero-wait:
  - Bus sequence is 0x2000 then 0x100 in back-to-back cycles.
  - `pause_o` high 3 cycles.
- Store 0xDEADBEEF, sel 4'b0011, 2 wait states:
  - `bus_wen_o`=1 and bus fields stable for 3 req cycles.
  - `mem_rdata_o` unchanged.
- Async `rst` asserted during DATA_WAIT:
  - `bus_req_o` falls without a clock edge.
  - All outputs at reset values.
- With the macro and `TIMEOUT_CYCLES`=4, no ack on a load:
  - `bus_err_o` pulses once with `bus_err_instr_o`=0.
  - `mem_rdata_o`=0 and `pause_o` releases.
- Release edge: after completion `pause_o` goes low, and a new request in the next cycle re-asserts `pause_o`, which proves the flags cleared.
